// File: rtl/stage2_window_gen.sv
// Raster-order KXxKY sliding-window generator (valid conv, stride 1).
// Buffers KY-1 rows and emits one packed window per qualifying pixel.
module stage2_window_gen #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int KX    = 5,
    parameter int KY    = 5,
    parameter int IBW   = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_in_valid,
    input  logic [IBW-1:0]              i_in_pixel,
    output logic                        o_ot_valid,
    output logic [KX*KY*IBW-1:0]        o_ot_fmap,
    output logic [$clog2(IMG_H)-1:0]    o_ot_row,
    output logic [$clog2(IMG_W)-1:0]    o_ot_col,
    output logic                        o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KY - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [IBW-1:0]       lb       [KY-1][IMG_W];
    logic [IBW-1:0]       win      [KY][KX];
    logic [IBW-1:0]       win_next [KY][KX];
    logic [IBW-1:0]       new_col  [KY];
    logic [KX*KY*IBW-1:0] fmap_next;
    logic                 hit;
    logic                 last_px;

    // lb[KY-2] holds the oldest row, so it lands at the top of the column
    always_comb begin
        for (int y = 0; y < KY - 1; y++) begin
            new_col[y] = lb[KY-2-y][col];
        end
        new_col[KY-1] = i_in_pixel;
        for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX - 1; x++) begin
                win_next[y][x] = win[y][x+1];
            end
            win_next[y][KX-1] = new_col[y];
        end
        fmap_next = '0;
        for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX; x++) begin
                fmap_next[(y*KX+x)*IBW +: IBW] = win_next[y][x];
            end
        end
    end

    assign hit = i_in_valid && !i_clear && (row >= ROW_MIN) && (col >= COL_MIN);
    assign last_px = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_ot_row     <= '0;
            o_ot_col     <= '0;
            o_frame_done <= 1'b0;
            for (int k = 0; k < KY - 1; k++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    lb[k][c] <= '0;
                end
            end
            for (int y = 0; y < KY; y++) begin
                for (int x = 0; x < KX; x++) begin
                    win[y][x] <= '0;
                end
            end
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_clear) begin
                col <= '0;
                row <= '0;
                for (int y = 0; y < KY; y++) begin
                    for (int x = 0; x < KX; x++) begin
                        win[y][x] <= '0;
                    end
                end
            end else if (i_in_valid) begin
                for (int y = 0; y < KY; y++) begin
                    for (int x = 0; x < KX; x++) begin
                        win[y][x] <= win_next[y][x];
                    end
                end
                lb[0][col] <= i_in_pixel;
                for (int k = 1; k < KY - 1; k++) begin
                    lb[k][col] <= lb[k-1][col];
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (hit) begin
                    o_ot_valid   <= 1'b1;
                    o_ot_fmap    <= fmap_next;
                    o_ot_row     <= row - ROW_MIN;
                    o_ot_col     <= col - COL_MIN;
                    o_frame_done <= last_px;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage2_window_gen.sv
// Scoreboard bench for stage2_window_gen: a frame-image model predicts
// every window, pushed on drive and popped when the DUT strobes.
module tb_stage2_window_gen;

    localparam int IMG_W = 12;
    localparam int IMG_H = 12;
    localparam int KX    = 5;
    localparam int KY    = 5;
    localparam int IBW   = 20;
    localparam int FW    = KX*KY*IBW;

    typedef struct {
        logic [FW-1:0] fmap;
        logic [3:0]    row;
        logic [3:0]    col;
        logic          done;
        int            cyc;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            clear;
    logic            in_valid;
    logic [IBW-1:0]  in_pixel;
    logic            ot_valid;
    logic [FW-1:0]   ot_fmap;
    logic [3:0]      ot_row;
    logic [3:0]      ot_col;
    logic            frame_done;

    stage2_window_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KX(KX), .KY(KY), .IBW(IBW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (clear),
        .i_in_valid   (in_valid),
        .i_in_pixel   (in_pixel),
        .o_ot_valid   (ot_valid),
        .o_ot_fmap    (ot_fmap),
        .o_ot_row     (ot_row),
        .o_ot_col     (ot_col),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwin = 0;
    int ndone = 0;
    int mr = 0;
    int mc = 0;
    logic [IBW-1:0] img [IMG_H][IMG_W];
    exp_t sb [$];
    exp_t mon_e;
    logic [FW-1:0] last_fmap = '0;

    task automatic check(input string tag, input logic [FW-1:0] got,
                         input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            last_fmap = '0;
        end else if (ot_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", FW'(1), FW'(0));
            end else begin
                mon_e = sb.pop_front();
                check("latency", FW'(cyc), FW'(mon_e.cyc));
                check("fmap", ot_fmap, mon_e.fmap);
                check("row", FW'(ot_row), FW'(mon_e.row));
                check("col", FW'(ot_col), FW'(mon_e.col));
                check("frame_done", FW'(frame_done), FW'(mon_e.done));
                last_fmap = mon_e.fmap;
                nwin++;
                if (frame_done) ndone++;
            end
        end else begin
            check("hold_fmap", ot_fmap, last_fmap);
            if (frame_done) check("done_no_valid", FW'(1), FW'(0));
        end
    end

    task automatic drive(input logic [IBW-1:0] p);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        img[mr][mc] = p;
        if (mr >= KY - 1 && mc >= KX - 1) begin
            e.fmap = '0;
            for (int y = 0; y < KY; y++) begin
                for (int x = 0; x < KX; x++) begin
                    e.fmap[(y*KX+x)*IBW +: IBW] = img[mr-(KY-1)+y][mc-(KX-1)+x];
                end
            end
            e.row  = 4'(mr - (KY - 1));
            e.col  = 4'(mc - (KX - 1));
            e.done = (mr == IMG_H - 1) && (mc == IMG_W - 1);
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            mr = (mr == IMG_H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic frame(input int base, input int gap, input bit ext,
                         input int npix);
        logic [IBW-1:0] p;
        for (int i = 0; i < npix; i++) begin
            if (ext) p = (i % 2 == 1) ? 20'h7FFFF : 20'h80000;
            else     p = IBW'(base + mr*16 + mc);
            drive(p);
            for (int g = 0; g < gap; g++) idle();
        end
        idle();
        idle();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, FW'(ot_valid), FW'(0));
        check({tag, "_fmap"}, ot_fmap, FW'(0));
        check({tag, "_row"}, FW'(ot_row), FW'(0));
        check({tag, "_col"}, FW'(ot_col), FW'(0));
        check({tag, "_done"}, FW'(frame_done), FW'(0));
    endtask

    int w0;
    int d0;

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        idle();

        // 1: ramp frame
        w0 = nwin; d0 = ndone;
        frame(0, 0, 1'b0, IMG_W*IMG_H);
        check("t1_windows", FW'(nwin - w0), FW'(64));
        check("t1_done", FW'(ndone - d0), FW'(1));

        // 2: 1-on/2-off valid pattern
        w0 = nwin; d0 = ndone;
        frame(0, 2, 1'b0, IMG_W*IMG_H);
        check("t2_windows", FW'(nwin - w0), FW'(64));
        check("t2_done", FW'(ndone - d0), FW'(1));

        // 3: back-to-back frames, second offset by 0x100
        w0 = nwin; d0 = ndone;
        for (int i = 0; i < IMG_W*IMG_H; i++) drive(IBW'(mr*16 + mc));
        for (int i = 0; i < IMG_W*IMG_H; i++) drive(IBW'(32'h100 + mr*16 + mc));
        idle();
        idle();
        check("t3_windows", FW'(nwin - w0), FW'(128));
        check("t3_done", FW'(ndone - d0), FW'(2));

        // 4: clear after 30 pixels, pixel in the clear cycle is dropped
        frame(0, 0, 1'b0, 30);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_pixel = 20'h5A5A5;
        mr = 0;
        mc = 0;
        idle();
        w0 = nwin; d0 = ndone;
        frame(0, 0, 1'b0, IMG_W*IMG_H);
        check("t4_windows", FW'(nwin - w0), FW'(64));
        check("t4_done", FW'(ndone - d0), FW'(1));

        // 5: reset mid-frame at pixel 70
        frame(0, 0, 1'b0, 70);
        check("t5_queue_drained", FW'(sb.size()), FW'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("t5_reset");
        mr = 0;
        mc = 0;
        @(negedge clk);
        reset = 1'b0;
        idle();
        w0 = nwin; d0 = ndone;
        frame(0, 0, 1'b0, IMG_W*IMG_H);
        check("t5_windows", FW'(nwin - w0), FW'(64));
        check("t5_done", FW'(ndone - d0), FW'(1));

        // 6: signed extremes
        w0 = nwin;
        frame(0, 0, 1'b1, IMG_W*IMG_H);
        check("t6_windows", FW'(nwin - w0), FW'(64));

        check("sb_empty", FW'(sb.size()), FW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
